// File: rtl/des_subkey_gen.sv
// Iterative DES key schedule: one 48-bit round subkey per accepted handshake,
// K1..K16 for encryption or K16..K1 (right rotations) for decryption.
`timescale 1ns/1ps
module des_subkey_gen #(
  parameter bit AUTO_ACK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] p;
    for (int i = 0; i < 56; i++) p[55-i] = k[64-PC1[i]];
    return p;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] p;
    for (int i = 0; i < 48; i++) p[47-i] = cd[56-PC2[i]];
    return p;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v, input logic dec, input logic two);
    if (!dec) return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    else      return two ? {v[1:0], v[27:2]}   : {v[0], v[27:1]};
  endfunction

  state_t      r_state;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_round;
  logic        r_dec, r_valid, r_busy, r_done;

  logic [55:0] w_pc1;
  logic        w_accept;
  logic        w_two;

  assign w_pc1    = pc1(key);
  assign w_accept = r_valid & (subkey_ready | AUTO_ACK);
  // Single-bit steps fall after rounds 1, 8 and 15 in both directions.
  assign w_two    = !((r_round == 4'd0) || (r_round == 4'd7) || (r_round == 4'd14));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Decrypt starts at PC-1 directly: the full schedule shifts by 28.
            r_c     <= decrypt ? w_pc1[55:28] : rot(w_pc1[55:28], 1'b0, 1'b0);
            r_d     <= decrypt ? w_pc1[27:0]  : rot(w_pc1[27:0],  1'b0, 1'b0);
            r_dec   <= decrypt;
            r_round <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_accept) begin
            if (r_round == 4'd15) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_round <= '0;
            end else begin
              r_round <= r_round + 4'd1;
              r_c     <= rot(r_c, r_dec, w_two);
              r_d     <= rot(r_d, r_dec, w_two);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign subkey       = pc2({r_c, r_d});
  assign subkey_valid = r_valid;
  assign round        = r_round;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Bench for des_subkey_gen: random keys and ready patterns against a
// bit-level FIPS key-schedule model using cumulative rotation counts.
`timescale 1ns/1ps
module tb_des_subkey_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, decrypt, subkey_ready;
  logic [63:0] key;
  logic        subkey_valid, busy, done;
  logic [47:0] subkey;
  logic [3:0]  round;

  logic        aa_start, aa_decrypt, aa_ready;
  logic [63:0] aa_key;
  logic        aa_valid, aa_busy, aa_done;
  logic [47:0] aa_subkey;
  logic [3:0]  aa_round;

  always #5 clk = ~clk;

  des_subkey_gen #(.AUTO_ACK(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .decrypt(decrypt),
    .subkey_ready(subkey_ready), .subkey_valid(subkey_valid), .subkey(subkey),
    .round(round), .busy(busy), .done(done));

  des_subkey_gen #(.AUTO_ACK(1'b1)) dut_aa (
    .clk(clk), .rst(rst), .start(aa_start), .key(aa_key), .decrypt(aa_decrypt),
    .subkey_ready(aa_ready), .subkey_valid(aa_valid), .subkey(aa_subkey),
    .round(aa_round), .busy(aa_busy), .done(aa_done));

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KNOWN_KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY_MASK = 64'h0101010101010101;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_k   [16];
  logic [47:0] got     [16];
  logic [47:0] enc_got [16];
  logic        cur_dec;

  // K1..K16 from the DES bit-numbered definition: Kn = PC-2 of C0/D0 rotated
  // left by the running total of the shift table.
  task automatic compute_ref(input logic [63:0] k);
    logic c0 [1:28];
    logic d0 [1:28];
    int   tot, p;
    for (int j = 1; j <= 28; j++) begin
      c0[j] = k[64-PC1[j-1]];
      d0[j] = k[64-PC1[j+27]];
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SH[r];
      for (int i = 0; i < 48; i++) begin
        p = PC2[i];
        if (p <= 28) exp_k[r][47-i] = c0[((p - 1 + tot) % 28) + 1];
        else         exp_k[r][47-i] = d0[((p - 29 + tot) % 28) + 1];
      end
    end
  endtask

  function automatic logic [47:0] expected_at(input int idx);
    return cur_dec ? exp_k[15-idx] : exp_k[idx];
  endfunction

  task automatic start_sched(input logic [63:0] k, input logic dec);
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    cur_dec = dec;
    compute_ref(k);
  endtask

  // Follows one schedule from the cycle after start through the done pulse.
  task automatic check_stream(input bit rand_ready, input bit disturb, input bit chain,
                              input logic [63:0] nkey, input logic ndec);
    int   idx = 0;
    int   cyc = 0;
    bit   disturbed = 0;
    logic r;
    logic [54:0] act, expv;
    @(negedge clk);
    start = 1'b0;
    while (idx < 16 && cyc < 400) begin
      start = 1'b0;
      if (disturb && idx == 5 && !disturbed) begin
        disturbed = 1;
        start   = 1'b1;
        key     = ~key;
        decrypt = ~decrypt;
      end
      act  = {subkey_valid, busy, done, round, subkey};
      expv = {1'b1, 1'b1, 1'b0, 4'(idx), expected_at(idx)};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL stream idx=%0d: got {v,b,d,rnd,key}=%h expected %h", idx, act, expv);
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      subkey_ready = r;
      if (r) begin
        got[idx] = subkey;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (idx < 16) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: accepted %0d expected 16", idx);
    end
    checks++;
    if ({subkey_valid, busy, done, round} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL done_pulse: got v=%b b=%b d=%b rnd=%0d expected v=0 b=0 d=1 rnd=0",
               subkey_valid, busy, done, round);
    end
    if (chain) start_sched(nkey, ndec);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; decrypt = 1'b0; subkey_ready = 1'b0;
    aa_start = 1'b0; aa_key = '0; aa_decrypt = 1'b0; aa_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({subkey_valid, busy, done, round, subkey} !== 55'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {subkey_valid, busy, done, round, subkey});
    end
    checks++;
    if ({aa_valid, aa_busy, aa_done, aa_round, aa_subkey} !== 55'd0) begin
      errors++;
      $display("FAIL reset_state_aa: got %h expected 0", {aa_valid, aa_busy, aa_done, aa_round, aa_subkey});
    end
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    @(negedge clk);
    start_sched(KNOWN_KEY, 1'b0);
    check_stream(0, 0, 0, '0, 1'b0);
    for (int i = 0; i < 16; i++) enc_got[i] = got[i];
    checks++;
    if ({got[0], got[1], got[15]} !== {48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'hCB3D8B0E17F5}) begin
      errors++;
      $display("FAIL known_enc: got %h %h %h expected 1b02effc7072 79aed9dbc9e5 cb3d8b0e17f5",
               got[0], got[1], got[15]);
    end
    @(negedge clk);
    start_sched(KNOWN_KEY, 1'b1);
    check_stream(0, 0, 0, '0, 1'b0);
    checks++;
    if ({got[0], got[1], got[15]} !== {48'hCB3D8B0E17F5, 48'hBF918D3D3F0A, 48'h1B02EFFC7072}) begin
      errors++;
      $display("FAIL known_dec: got %h %h %h expected cb3d8b0e17f5 bf918d3d3f0a 1b02effc7072",
               got[0], got[1], got[15]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== enc_got[15-i]) begin
        errors++;
        $display("FAIL dec_reverse[%0d]: got %h expected %h", i, got[i], enc_got[15-i]);
      end
    end
  endtask

  task automatic test_random_schedules();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      start_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      check_stream(0, 0, 0, '0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      start_sched({$urandom, $urandom}, 1'(n));
      check_stream(1, 0, 0, '0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    @(negedge clk);
    subkey_ready = 1'b1;
    start_sched({$urandom, $urandom}, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (!(subkey_valid && round == 4'd7) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (round !== 4'd7) begin
      errors++;
      $display("FAIL reach_round7: got %0d expected 7", round);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({subkey_valid, busy, done, round, subkey} !== 55'd0) begin
      errors++;
      $display("FAIL async_reset_mid: got %h expected 0", {subkey_valid, busy, done, round, subkey});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_sched({$urandom, $urandom}, 1'b1);
    check_stream(0, 0, 0, '0, 1'b0);
  endtask

  task automatic test_disturb();
    @(negedge clk);
    start_sched({$urandom, $urandom}, 1'b0);
    check_stream(0, 1, 0, '0, 1'b0);
    @(negedge clk);
    start_sched({$urandom, $urandom}, 1'b1);
    check_stream(1, 1, 0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_sched({$urandom, $urandom}, 1'b0);
    check_stream(0, 0, 1, {$urandom, $urandom}, 1'b1);
    check_stream(0, 0, 1, {$urandom, $urandom}, 1'b0);
    check_stream(0, 0, 0, '0, 1'b0);
  endtask

  task automatic test_auto_ack();
    logic [63:0] k;
    logic [54:0] act, expv;
    k = {$urandom, $urandom};
    compute_ref(k);
    aa_ready = 1'b0;
    for (int it = 0; it < 2; it++) begin
      @(negedge clk);
      aa_key     = (it == 0) ? k : (k ^ PARITY_MASK);
      aa_decrypt = 1'(it);
      aa_start   = 1'b1;
      cur_dec    = 1'(it);
      @(negedge clk);
      aa_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        act  = {aa_valid, aa_busy, aa_done, aa_round, aa_subkey};
        expv = {1'b1, 1'b1, 1'b0, 4'(i), expected_at(i)};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL auto_ack it=%0d i=%0d: got %h expected %h", it, i, act, expv);
        end
        @(negedge clk);
      end
      checks++;
      if ({aa_valid, aa_busy, aa_done} !== 3'b001) begin
        errors++;
        $display("FAIL auto_ack_done it=%0d: got v,b,d=%b expected 001", it, {aa_valid, aa_busy, aa_done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_schedules();
    test_backpressure();
    test_reset_mid();
    test_disturb();
    test_back_to_back();
    test_auto_ack();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_subkey_gen.md
Name: des_subkey_gen

Overview:
Iterative DES key schedule that produces the 48-bit round subkeys the round datapath XORs with the E-expanded half-block before the S-box substitution stage. It emits one subkey per accepted handshake, for rounds 1..16. In encrypt mode the order is K1..K16. In decrypt mode it runs the schedule in the opposite direction, K16..K1, using right rotations. It sits between the key register and the round engine.

Parameters:
AUTO_ACK, 0, when 1 subkey_ready is ignored and treated as 1, so one subkey is issued per clock.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  begin a schedule; sampled only in IDLE
key  input  64  DES key; bit 63 is DES bit 1; parity bits 8,16,..,64 are ignored
decrypt  input  1  sampled with start; 0 selects K1..K16, 1 selects K16..K1
subkey_ready  input  1  consumer accepts the current subkey
subkey_valid  output  1  subkey and round are valid
subkey  output  48  PC-2 result; bit 47 is DES subkey bit 1
round  output  4  index of the current subkey in emission order, 0..15
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the 16th subkey is accepted

Behaviour:
- Permutations: PC-1 and PC-2 and the shift schedule exactly per FIPS 46-3, with DES bit n mapped to vector bit (width-n).
- State: 28-bit C and D registers.
- subkey output: combinational PC-2 of {C,D}.
- FSM states: IDLE and EMIT.
- IDLE:
  - subkey_valid=0, busy=0.
  - start=1 loads {C,D} from PC-1(key) and enters EMIT.
  - Encrypt load: both halves are rotated left by 1 at load.
  - Decrypt load: no rotation, because the total shift over the schedule is 28, so PC-1 itself yields K16.
  - The decrypt flag is latched at load. Sets round=0.
- EMIT:
  - subkey_valid=1, busy=1.
  - Accept = subkey_valid & (subkey_ready | AUTO_ACK).
  - On accept with round<15: round increments and C,D rotate.
  - Encrypt rotation: left by s(round+2), where s(i)=1 for i in {1,2,9,16} and 2 otherwise.
  - Decrypt rotation: right by r(round+2), where r(j)=1 for j in {2,9,16} and 2 otherwise.
  - On accept with round==15: go to IDLE, pulse done=1 for one cycle, subkey_valid=0, round=0.
- Latency:
  - First subkey is valid the cycle after start is sampled.
  - With AUTO_ACK, or with ready held high, 16 consecutive valid cycles follow; done is asserted on the cycle after the last one.
- Stall: while valid & !ready, subkey, round and C/D hold stable.
- start while busy is ignored. No restart and no abort.
- key and decrypt changing after the load cycle have no effect.
- Reset (any time, including mid-schedule): FSM=IDLE, C=D=0, round=0, subkey_valid=0, busy=0, done=0, so subkey reads PC-2(0)=0. Any in-progress schedule is abandoned.
- start on the same cycle done pulses: the FSM is already in IDLE, so start is accepted and a new schedule begins the next cycle.

Test Plan:
- Encrypt, key=0x133457799BBCDFF1, ready=1 -> round0 subkey=0x1B02EFFC7072, round1=0x79AED9DBC9E5, round15=0xCB3D8B0E17F5; done one cycle after round15.
- Decrypt, same key -> round0=0xCB3D8B0E17F5, round1=0xBF918D3D3F0A, round15=0x1B02EFFC7072; full sequence equals the encrypt sequence reversed.
- Backpressure: ready toggled randomly -> each subkey/round held stable while ready=0; exactly 16 accepts; order matches the ready=1 run.
- Reset asserted at round 7 of a schedule -> outputs 0 immediately (asynchronous); new start after release gives a correct full schedule.
- start pulsed while busy, and key changed mid-run -> ignored; sequence unchanged. start coincident with done -> next schedule begins seamlessly.
- AUTO_ACK=1, subkey_ready=0 -> 16 subkeys on 16 consecutive cycles; parity-bit flips in key do not change any subkey.
